// File: rtl/alu_nibble_sequencer_pkg.sv
// alu_nibble_sequencer_pkg: shared state encoding and nibble width for the ALU nibble sequencer
package alu_nibble_sequencer_pkg;
  localparam int NIB = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: streams wide operands nibble by nibble through a 4-bit ALU slice and reassembles the result
module alu_nibble_sequencer
  import alu_nibble_sequencer_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NIB*NIBBLES-1:0] op_a,
  input  logic [NIB*NIBBLES-1:0] op_b,
  input  logic                   op_m,
  input  logic [3:0]             op_s,
  input  logic                   op_cin,
  output logic                   ready,
  output logic                   done,
  output logic [NIB*NIBBLES-1:0] result,
  output logic                   res_cout,
  output logic                   res_zero,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic                   alu_m,
  output logic [3:0]             alu_s,
  output logic                   alu_cin,
  input  logic [3:0]             alu_f,
  input  logic                   alu_cout
);
  localparam int W  = NIB * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   a_q, b_q, acc_q, acc_d, result_q;
  logic           m_q, carry_q, last_cin_q, cout_q, zero_q;
  logic [3:0]     s_q;
  logic           last;
  assign last = cnt_q == CW'(NIBBLES - 1);
  // state, operand latches, nibble accumulation and the result published on the final nibble
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      m_q        <= 1'b0;
      s_q        <= 4'h0;
      carry_q    <= 1'b1;
      last_cin_q <= 1'b0;
      acc_q      <= '0;
      result_q   <= '0;
      cout_q     <= 1'b1;
      zero_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        a_q     <= op_a;
        b_q     <= op_b;
        m_q     <= op_m;
        s_q     <= op_s;
        carry_q <= op_cin;
        cnt_q   <= '0;
      end
      if (state_q == RUN) begin
        acc_q      <= acc_d;
        carry_q    <= alu_cout;
        last_cin_q <= carry_q;
        if (last) begin
          result_q <= acc_d;
          zero_q   <= acc_d == '0;
          cout_q   <= m_q ? 1'b1 : alu_cout;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end
  // next state: IDLE -> RUN on start, RUN -> DONE after the top nibble, DONE -> IDLE
  always_comb begin
    state_d = (state_q == IDLE) ? (start ? RUN : IDLE) :
              (state_q == RUN)  ? (last ? DONE : RUN)  : IDLE;
  end
  // merge the current ALU nibble into the partial result
  always_comb begin
    acc_d = acc_q;
    acc_d[cnt_q*NIB +: NIB] = alu_f;
  end
  // outputs come from registers only; alu_cin keeps its last driven value outside RUN
  always_comb begin
    ready    = state_q == IDLE;
    done     = state_q == DONE;
    result   = result_q;
    res_cout = cout_q;
    res_zero = zero_q;
    alu_a    = a_q[cnt_q*NIB +: NIB];
    alu_b    = b_q[cnt_q*NIB +: NIB];
    alu_m    = m_q;
    alu_s    = s_q;
    alu_cin  = (state_q == RUN) ? carry_q : last_cin_q;
  end
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// tb_alu_nibble_sequencer: directed end-to-end checks of the nibble sequencer driving a 74181-style ALU model
module tb_alu_nibble_sequencer;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [15:0] op_a = '0, op_b = '0;
  logic        op_m = 1'b0, op_cin = 1'b1;
  logic [3:0]  op_s = 4'h0;
  logic        ready, done, res_cout, res_zero, alu_m, alu_cin, alu_cout;
  logic [15:0] result;
  logic [3:0]  alu_a, alu_b, alu_s, alu_f;
  int          n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  // 4-bit ALU slice, active-high data, active-low carries
  function automatic logic [4:0] alu181(input logic [3:0] a, b, s, input logic m, cn);
    logic [3:0] t1, t2;
    logic [4:0] sum;
    t1  = a | (s[0] ? b : 4'h0) | (s[1] ? ~b : 4'h0);
    t2  = (s[3] ? (a & b) : 4'h0) | (s[2] ? (a & ~b) : 4'h0);
    sum = {1'b0, t1} + {1'b0, t2} + {4'h0, ~cn};
    return m ? {1'b1, ~(t1 ^ t2)} : {~sum[4], sum[3:0]};
  endfunction

  assign {alu_cout, alu_f} = alu181(alu_a, alu_b, alu_s, alu_m, alu_cin);

  alu_nibble_sequencer #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .op_a(op_a), .op_b(op_b), .op_m(op_m), .op_s(op_s), .op_cin(op_cin),
    .ready(ready), .done(done), .result(result), .res_cout(res_cout), .res_zero(res_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_m(alu_m), .alu_s(alu_s), .alu_cin(alu_cin),
    .alu_f(alu_f), .alu_cout(alu_cout)
  );

  // issue one operation, scramble inputs after accept, return edges (accept edge = 1) until done and alu_cin per nibble
  task automatic do_op(input logic [15:0] a, b, input logic m, input logic [3:0] s, input logic cin,
                       output int edges, output logic [3:0] seq);
    edges = -1;
    seq   = 4'h0;
    @(posedge clk); #1;
    op_a = a; op_b = b; op_m = m; op_s = s; op_cin = cin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op_a = 16'($urandom); op_b = 16'($urandom); op_m = 1'($urandom);
    op_s = 4'($urandom); op_cin = 1'($urandom);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done) begin
        edges = n;
        break;
      end
      if (n <= 4) seq[n-1] = alu_cin;
      @(posedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (result !== 16'h0) begin n_fail++; $display("FAIL reset_result got %h want 0000", result); end
    n_checks++; if ({res_cout, res_zero} !== 2'b11) begin n_fail++; $display("FAIL reset_flags got %b want 11", {res_cout, res_zero}); end
    n_checks++; if ({alu_a, alu_b, alu_m, alu_s, alu_cin} !== 14'h0) begin n_fail++; $display("FAIL reset_alu got %h want 0", {alu_a, alu_b, alu_m, alu_s, alu_cin}); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_add;
    int e; logic [3:0] sq;
    do_op(16'h1234, 16'h0FFF, 1'b0, 4'h9, 1'b1, e, sq);
    n_checks++; if (e !== 5) begin n_fail++; $display("FAIL add_latency got %0d want 5", e); end
    n_checks++; if (result !== 16'h2233) begin n_fail++; $display("FAIL add_result got %h want 2233", result); end
    n_checks++; if ({res_cout, res_zero} !== 2'b10) begin n_fail++; $display("FAIL add_flags got %b want 10", {res_cout, res_zero}); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL add_ready_in_done got %b want 0", ready); end
    @(negedge clk);
    n_checks++; if ({done, ready} !== 2'b01) begin n_fail++; $display("FAIL add_done_pulse got %b want 01", {done, ready}); end
    n_checks++; if ({alu_a, alu_b, alu_s} !== 12'h109) begin n_fail++; $display("FAIL add_alu_hold got %h want 109", {alu_a, alu_b, alu_s}); end
  endtask

  task automatic test_carry_ripple;
    int e; logic [3:0] sq;
    do_op(16'hFFFF, 16'h0001, 1'b0, 4'h9, 1'b1, e, sq);
    n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL ripple_result got %h want 0000", result); end
    n_checks++; if ({res_cout, res_zero} !== 2'b01) begin n_fail++; $display("FAIL ripple_flags got %b want 01", {res_cout, res_zero}); end
    n_checks++; if (sq !== 4'b0001) begin n_fail++; $display("FAIL ripple_cin_seq got %b want 0001", sq); end
  endtask

  task automatic test_subtract;
    int e; logic [3:0] sq;
    do_op(16'h5000, 16'h1234, 1'b0, 4'h6, 1'b0, e, sq);
    n_checks++; if (result !== 16'h3DCC) begin n_fail++; $display("FAIL sub_result got %h want 3dcc", result); end
    n_checks++; if ({res_cout, res_zero} !== 2'b00) begin n_fail++; $display("FAIL sub_flags got %b want 00", {res_cout, res_zero}); end
    n_checks++; if (sq !== 4'b1110) begin n_fail++; $display("FAIL sub_cin_seq got %b want 1110", sq); end
  endtask

  task automatic test_logic_and;
    int e; logic [3:0] sq;
    do_op(16'hF0F0, 16'hFF00, 1'b1, 4'hB, 1'b1, e, sq);
    n_checks++; if (result !== 16'hF000) begin n_fail++; $display("FAIL and_result got %h want f000", result); end
    n_checks++; if ({res_cout, res_zero} !== 2'b10) begin n_fail++; $display("FAIL and_flags got %b want 10", {res_cout, res_zero}); end
  endtask

  task automatic test_back_to_back;
    int pulses, at;
    pulses = 0; at = -1;
    @(posedge clk); #1;
    op_a = 16'h1234; op_b = 16'h0FFF; op_m = 1'b0; op_s = 4'h9; op_cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    op_a = 16'h1111; op_b = 16'h2222;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        at = n;
        n_checks++; if (result !== 16'h2233) begin n_fail++; $display("FAIL b2b_first_result got %h want 2233", result); end
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_in_done got %b want 0", ready); end
      end
      @(posedge clk);
    end
    n_checks++; if (pulses !== 1 || at !== 5) begin n_fail++; $display("FAIL b2b_done_pulses got %0d at %0d want 1 at 5", pulses, at); end
    @(negedge clk);
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_done got %b want 1", ready); end
    @(posedge clk); #1;
    start = 1'b0;
    at = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done) begin at = n; break; end
      @(posedge clk);
    end
    n_checks++; if (at !== 5) begin n_fail++; $display("FAIL b2b_second_latency got %0d want 5", at); end
    n_checks++; if (result !== 16'h3333) begin n_fail++; $display("FAIL b2b_second_result got %h want 3333", result); end
  endtask

  task automatic test_reset_mid_run;
    int pulses, e; logic [3:0] sq;
    pulses = 0;
    @(posedge clk); #1;
    op_a = 16'hFFFF; op_b = 16'h0001; op_m = 1'b0; op_s = 4'h9; op_cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if ({ready, done} !== 2'b10) begin n_fail++; $display("FAIL rst_mid_state got %b want 10", {ready, done}); end
    n_checks++; if (result !== 16'h0) begin n_fail++; $display("FAIL rst_mid_result got %h want 0000", result); end
    n_checks++; if ({res_cout, res_zero, alu_a, alu_cin} !== 7'b1100000) begin n_fail++; $display("FAIL rst_mid_regs got %b want 1100000", {res_cout, res_zero, alu_a, alu_cin}); end
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL rst_mid_no_done got %0d want 0", pulses); end
    do_op(16'h5000, 16'h1234, 1'b0, 4'h6, 1'b0, e, sq);
    n_checks++; if (e !== 5 || result !== 16'h3DCC) begin n_fail++; $display("FAIL rst_mid_fresh got %0d/%h want 5/3dcc", e, result); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_carry_ripple;
    test_subtract;
    test_logic_and;
    test_back_to_back;
    test_reset_mid_run;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
